// File: rtl/id_exe_forward_pkg.sv
// Shared bexkat1 definitions: datapath widths, bypass select codes and the
// ID/EXE stage payload.
package bexkat1Def;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IR_W   = 64;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        FWD_REG    = 3'd0,
        FWD_MEM    = 3'd1,
        FWD_EXE    = 3'd2,
        FWD_MEM_SP = 3'd3,
        FWD_EXE_SP = 3'd4
    } fwd_sel_t;

    typedef enum logic [1:0] {
        SPF_REG = 2'd0,
        SPF_EXE = 2'd1,
        SPF_MEM = 2'd2
    } sp_fwd_t;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] sp;
    } exe_stage_t;

endpackage

// File: rtl/id_exe_forward_if.sv
// ID/EXE boundary bundle: decoded instruction, hazard codes, bypass sources
// and the registered EXE-stage view.
interface id_exe_forward_if;
    import bexkat1Def::*;

    logic [IR_W-1:0]   id_ir;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_reg1;
    logic [DATA_W-1:0] id_reg2;
    logic [DATA_W-1:0] id_sp;
    logic              stall;
    logic              flush;
    logic [2:0]        hazard1;
    logic [2:0]        hazard2;
    logic [1:0]        sp_hazard;
    logic [DATA_W-1:0] exe_result;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] exe_sp_data;
    logic [DATA_W-1:0] mem_sp_data;

    logic [IR_W-1:0]   exe_ir;
    logic [DATA_W-1:0] exe_pc;
    logic [DATA_W-1:0] exe_op1;
    logic [DATA_W-1:0] exe_op2;
    logic [DATA_W-1:0] exe_sp;
    logic              fwd_illegal;
    logic [CNT_W-1:0]  fwd_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_ir, id_pc, id_reg1, id_reg2, id_sp, stall, flush,
               hazard1, hazard2, sp_hazard,
               exe_result, mem_result, exe_sp_data, mem_sp_data,
        input  exe_ir, exe_pc, exe_op1, exe_op2, exe_sp,
               fwd_illegal, fwd_count, stall_count
    );

    modport slave (
        input  id_ir, id_pc, id_reg1, id_reg2, id_sp, stall, flush,
               hazard1, hazard2, sp_hazard,
               exe_result, mem_result, exe_sp_data, mem_sp_data,
        output exe_ir, exe_pc, exe_op1, exe_op2, exe_sp,
               fwd_illegal, fwd_count, stall_count
    );

endinterface

// File: rtl/id_exe_forward_fwd_mux.sv
// Operand bypass select: 5:1 mux with a flag for undefined select codes,
// which fall back to the register-file value.
module fwd_mux
    import bexkat1Def::*;
(
    input  fwd_sel_t          sel,
    input  logic [DATA_W-1:0] reg_val,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] mem_sp_data,
    input  logic [DATA_W-1:0] exe_sp_data,
    output logic [DATA_W-1:0] val_c,
    output logic              illegal_c
);

    always_comb begin
        val_c     = reg_val;
        illegal_c = 1'b0;
        case (sel)
            FWD_REG:    val_c = reg_val;
            FWD_MEM:    val_c = mem_result;
            FWD_EXE:    val_c = exe_result;
            FWD_MEM_SP: val_c = mem_sp_data;
            FWD_EXE_SP: val_c = exe_sp_data;
            default:    illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_exe_forward.sv
// ID/EXE pipeline register with operand/SP bypass and bubble insertion.
// Define BEXKAT1_FWD_STATS_EN to build the forward/stall statistics counters.
module id_exe_forward
    import bexkat1Def::*;
(
    input logic             clk_i,
    input logic             rst_i,
    id_exe_forward_if.slave bus
);

    logic [DATA_W-1:0] op1_c;
    logic [DATA_W-1:0] op2_c;
    logic [DATA_W-1:0] sp_c;
    logic              ill1_c;
    logic              ill2_c;
    logic              illsp_c;
    logic              capture_c;
    logic              fwd_hit_c;

    exe_stage_t        stage_q;
    logic              illegal_q;

    fwd_mux u_op1 (
        .sel         (fwd_sel_t'(bus.hazard1)),
        .reg_val     (bus.id_reg1),
        .mem_result  (bus.mem_result),
        .exe_result  (bus.exe_result),
        .mem_sp_data (bus.mem_sp_data),
        .exe_sp_data (bus.exe_sp_data),
        .val_c       (op1_c),
        .illegal_c   (ill1_c)
    );

    fwd_mux u_op2 (
        .sel         (fwd_sel_t'(bus.hazard2)),
        .reg_val     (bus.id_reg2),
        .mem_result  (bus.mem_result),
        .exe_result  (bus.exe_result),
        .mem_sp_data (bus.mem_sp_data),
        .exe_sp_data (bus.exe_sp_data),
        .val_c       (op2_c),
        .illegal_c   (ill2_c)
    );

    // SP bypass select
    always_comb begin
        sp_c    = bus.id_sp;
        illsp_c = 1'b0;
        case (sp_fwd_t'(bus.sp_hazard))
            SPF_REG: sp_c = bus.id_sp;
            SPF_EXE: sp_c = bus.exe_sp_data;
            SPF_MEM: sp_c = bus.mem_sp_data;
            default: illsp_c = 1'b1;
        endcase
    end

    // A real instruction is loaded only when neither flush nor stall is active
    assign capture_c = !bus.flush && !bus.stall && (bus.id_ir != '0);
    assign fwd_hit_c = capture_c &&
                       ((bus.hazard1 != '0) || (bus.hazard2 != '0) || (bus.sp_hazard != '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (capture_c) begin
                stage_q <= '{ir: bus.id_ir, pc: bus.id_pc, op1: op1_c, op2: op2_c, sp: sp_c};
            end else begin
                stage_q <= '0;
            end
            if (capture_c && (ill1_c || ill2_c || illsp_c)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.exe_ir      = stage_q.ir;
    assign bus.exe_pc      = stage_q.pc;
    assign bus.exe_op1     = stage_q.op1;
    assign bus.exe_op2     = stage_q.op2;
    assign bus.exe_sp      = stage_q.sp;
    assign bus.fwd_illegal = illegal_q;

`ifdef BEXKAT1_FWD_STATS_EN
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating statistics counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fwd_hit_c && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
            if (bus.stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_count   = fwd_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    logic unused_fwd_hit;
    assign unused_fwd_hit  = fwd_hit_c;
    assign bus.fwd_count   = '0;
    assign bus.stall_count = '0;
`endif

endmodule
